// File: rtl/vx_writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results into one registered register-file write port.
// Define VX_WB_PERF_EN to add the out_perf_alu_stalls counter output.
module vx_writeback_arbiter #(
    parameter int NUM_THREADS    = 4,
    parameter int WARP_W         = 1,
    parameter int MEM_FIFO_DEPTH = 2,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_alu_valid,
    input  logic [WARP_W-1:0]         in_alu_warp,
    input  logic [NUM_THREADS-1:0]    in_alu_mask,
    input  logic                      in_alu_wb,
    input  logic [4:0]                in_alu_rd,
    input  logic [NUM_THREADS*32-1:0] in_alu_data,
    output logic                      out_alu_stall,
    input  logic                      in_mem_valid,
    input  logic [WARP_W-1:0]         in_mem_warp,
    input  logic [NUM_THREADS-1:0]    in_mem_mask,
    input  logic                      in_mem_wb,
    input  logic [4:0]                in_mem_rd,
    input  logic [NUM_THREADS*32-1:0] in_mem_data,
    output logic                      out_mem_ready,
    output logic [WARP_W-1:0]         out_wb_warp,
    output logic [NUM_THREADS-1:0]    out_valid,
    output logic                      out_write_register,
    output logic [4:0]                out_rd,
    output logic [NUM_THREADS*32-1:0] out_write_data
`ifdef VX_WB_PERF_EN
    ,
    output logic [31:0]               out_perf_alu_stalls
`endif
);

    localparam int DW = NUM_THREADS * 32;
    localparam int PW = (MEM_FIFO_DEPTH > 1) ? $clog2(MEM_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_MEM_STREAK + 1);
    localparam int EW = WARP_W + NUM_THREADS + 1 + 5 + DW;

    logic [EW-1:0]          fifo_mem [MEM_FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]          count_reg;
    logic [SW-1:0]          streak_reg;

    logic                   push, grant_mem, grant_alu;
    logic [WARP_W-1:0]      head_warp, sel_warp;
    logic [NUM_THREADS-1:0] head_mask, sel_mask;
    logic                   head_wb, sel_wb, sel_write;
    logic [4:0]             head_rd, sel_rd;
    logic [DW-1:0]          head_data, sel_data;

    assign {head_warp, head_mask, head_wb, head_rd, head_data} = fifo_mem[rd_ptr_reg];

    assign out_mem_ready = (count_reg != CW'(MEM_FIFO_DEPTH));
    assign push          = in_mem_valid && out_mem_ready;
    // A waiting ALU result wins once loads have taken MAX consecutive grants.
    assign grant_mem     = (count_reg != '0) &&
                           !(in_alu_valid && (streak_reg == SW'(MAX_MEM_STREAK)));
    assign grant_alu     = in_alu_valid && !grant_mem;
    assign out_alu_stall = in_alu_valid && !grant_alu;

    always_comb begin
        sel_warp = in_alu_warp;
        sel_mask = in_alu_mask;
        sel_wb   = in_alu_wb;
        sel_rd   = in_alu_rd;
        sel_data = in_alu_data;
        if (grant_mem) begin
            sel_warp = head_warp;
            sel_mask = head_mask;
            sel_wb   = head_wb;
            sel_rd   = head_rd;
            sel_data = head_data;
        end
    end

    assign sel_write = sel_wb && (sel_rd != 5'd0) && (sel_mask != '0);

    // Storage has no reset so it maps onto plain distributed/block memory.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {in_mem_warp, in_mem_mask, in_mem_wb, in_mem_rd, in_mem_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            streak_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PW'(MEM_FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            if (grant_mem)
                rd_ptr_reg <= (rd_ptr_reg == PW'(MEM_FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            case ({push, grant_mem})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (!in_alu_valid || grant_alu)
                streak_reg <= '0;
            else if (grant_mem && (streak_reg != SW'(MAX_MEM_STREAK)))
                streak_reg <= streak_reg + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wb_warp        <= '0;
            out_valid          <= '0;
            out_write_register <= 1'b0;
            out_rd             <= '0;
            out_write_data     <= '0;
        end else if (grant_mem || grant_alu) begin
            out_wb_warp        <= sel_warp;
            out_valid          <= sel_mask;
            out_write_register <= sel_write;
            out_rd             <= sel_rd;
            out_write_data     <= sel_data;
        end else begin
            out_valid          <= '0;
            out_write_register <= 1'b0;
        end
    end

`ifdef VX_WB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_perf_alu_stalls <= '0;
        else if (out_alu_stall)
            out_perf_alu_stalls <= out_perf_alu_stalls + 32'd1;
    end
`endif

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Directed bench for vx_writeback_arbiter: ALU vector table plus load, streak and reset sequences.
module tb_vx_writeback_arbiter;

    localparam int NT = 4;
    localparam int DW = NT * 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_alu_valid = 1'b0;
    logic [0:0]    in_alu_warp = '0;
    logic [NT-1:0] in_alu_mask = '0;
    logic          in_alu_wb = 1'b0;
    logic [4:0]    in_alu_rd = '0;
    logic [DW-1:0] in_alu_data = '0;
    logic          out_alu_stall;
    logic          in_mem_valid = 1'b0;
    logic [0:0]    in_mem_warp = '0;
    logic [NT-1:0] in_mem_mask = '0;
    logic          in_mem_wb = 1'b0;
    logic [4:0]    in_mem_rd = '0;
    logic [DW-1:0] in_mem_data = '0;
    logic          out_mem_ready;
    logic [0:0]    out_wb_warp;
    logic [NT-1:0] out_valid;
    logic          out_write_register;
    logic [4:0]    out_rd;
    logic [DW-1:0] out_write_data;
`ifdef VX_WB_PERF_EN
    logic [31:0]   out_perf_alu_stalls;
`endif

    vx_writeback_arbiter #(
        .NUM_THREADS(NT), .WARP_W(1), .MEM_FIFO_DEPTH(2), .MAX_MEM_STREAK(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_alu_valid(in_alu_valid), .in_alu_warp(in_alu_warp), .in_alu_mask(in_alu_mask),
        .in_alu_wb(in_alu_wb), .in_alu_rd(in_alu_rd), .in_alu_data(in_alu_data),
        .out_alu_stall(out_alu_stall),
        .in_mem_valid(in_mem_valid), .in_mem_warp(in_mem_warp), .in_mem_mask(in_mem_mask),
        .in_mem_wb(in_mem_wb), .in_mem_rd(in_mem_rd), .in_mem_data(in_mem_data),
        .out_mem_ready(out_mem_ready),
        .out_wb_warp(out_wb_warp), .out_valid(out_valid), .out_write_register(out_write_register),
        .out_rd(out_rd), .out_write_data(out_write_data)
`ifdef VX_WB_PERF_EN
        , .out_perf_alu_stalls(out_perf_alu_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          av;
        logic [0:0]    aw;
        logic [NT-1:0] am;
        logic          awb;
        logic [4:0]    ard;
        logic [DW-1:0] ad;
        logic          e_stall;
        logic          e_wr;
        logic [NT-1:0] e_valid;
        logic [4:0]    e_rd;
        logic [DW-1:0] e_data;
        logic [0:0]    e_warp;
    } vec_t;

    vec_t vecs[6];
    int   n_pass = 0;
    int   n_total = 0;

    int e4_stall[11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int e4_ready[11] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    int e4_rd[11]    = '{9, 10, 11, 12, 13, 9, 14, 15, 16, 17, 9};

    function automatic logic [DW-1:0] mkd(input int b);
        logic [DW-1:0] r;
        for (int i = 0; i < NT; i++) r[i*32 +: 32] = 32'(b + i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else begin
            n_pass++;
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic av, input logic [0:0] aw, input logic [NT-1:0] am,
                                 input logic awb, input logic [4:0] ard, input logic [DW-1:0] ad,
                                 input logic e_wr, input logic [NT-1:0] e_valid,
                                 input logic [4:0] e_rd, input logic [DW-1:0] e_data,
                                 input logic [0:0] e_warp);
        vec_t v;
        v.av = av; v.aw = aw; v.am = am; v.awb = awb; v.ard = ard; v.ad = ad;
        v.e_stall = 1'b0; v.e_wr = e_wr; v.e_valid = e_valid;
        v.e_rd = e_rd; v.e_data = e_data; v.e_warp = e_warp;
        return v;
    endfunction

    initial begin
        int k_push;
        logic pushed;

        vecs[0] = mkv(1, 1'b0, 4'b1111, 1, 5'd5,  mkd(1),  1, 4'b1111, 5'd5,  mkd(1),  1'b0);
        vecs[1] = mkv(1, 1'b1, 4'b1111, 1, 5'd0,  mkd(20), 0, 4'b1111, 5'd0,  mkd(20), 1'b1);
        vecs[2] = mkv(1, 1'b0, 4'b0000, 1, 5'd3,  mkd(30), 0, 4'b0000, 5'd3,  mkd(30), 1'b0);
        vecs[3] = mkv(1, 1'b1, 4'b0101, 0, 5'd4,  mkd(40), 0, 4'b0101, 5'd4,  mkd(40), 1'b1);
        vecs[4] = mkv(0, 1'b0, 4'b1111, 1, 5'd6,  mkd(50), 0, 4'b0000, 5'd4,  mkd(40), 1'b1);
        vecs[5] = mkv(1, 1'b0, 4'b1000, 1, 5'd31, mkd(60), 1, 4'b1000, 5'd31, mkd(60), 1'b0);

        // Reset state
        step(); step();
        chk("rst_wr", DW'(out_write_register), DW'(0));
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_rd", DW'(out_rd), DW'(0));
        chk("rst_data", out_write_data, DW'(0));
        chk("rst_ready", DW'(out_mem_ready), DW'(1));
        chk("rst_stall", DW'(out_alu_stall), DW'(0));
        reset = 1'b0;
        step();

        // ALU-only vectors, FIFO empty
        for (int i = 0; i < 6; i++) begin
            in_alu_valid = vecs[i].av; in_alu_warp = vecs[i].aw; in_alu_mask = vecs[i].am;
            in_alu_wb = vecs[i].awb; in_alu_rd = vecs[i].ard; in_alu_data = vecs[i].ad;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), DW'(out_alu_stall), DW'(vecs[i].e_stall));
            step();
            chk($sformatf("v%0d_wr", i), DW'(out_write_register), DW'(vecs[i].e_wr));
            chk($sformatf("v%0d_valid", i), DW'(out_valid), DW'(vecs[i].e_valid));
            chk($sformatf("v%0d_rd", i), DW'(out_rd), DW'(vecs[i].e_rd));
            chk($sformatf("v%0d_data", i), out_write_data, vecs[i].e_data);
            chk($sformatf("v%0d_warp", i), DW'(out_wb_warp), DW'(vecs[i].e_warp));
        end
        in_alu_valid = 1'b0;

        // Single load: visible after the second edge
        in_mem_valid = 1'b1; in_mem_warp = 1'b1; in_mem_mask = 4'b1111;
        in_mem_wb = 1'b1; in_mem_rd = 5'd7; in_mem_data = mkd(100);
        @(negedge clk);
        chk("ld_ready0", DW'(out_mem_ready), DW'(1));
        step();
        in_mem_valid = 1'b0;
        chk("ld_wr_e1", DW'(out_write_register), DW'(0));
        chk("ld_ready1", DW'(out_mem_ready), DW'(1));
        step();
        chk("ld_wr_e2", DW'(out_write_register), DW'(1));
        chk("ld_rd_e2", DW'(out_rd), DW'(7));
        chk("ld_data_e2", out_write_data, mkd(100));
        chk("ld_valid_e2", DW'(out_valid), DW'(4'b1111));
        chk("ld_warp_e2", DW'(out_wb_warp), DW'(1));
        step();
        chk("ld_wr_e3", DW'(out_write_register), DW'(0));

        // Three back-to-back loads with free drain
        in_mem_warp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_mem_valid = (k < 3);
            in_mem_rd = 5'(20 + k);
            in_mem_data = mkd(200 + k * 10);
            @(negedge clk);
            chk($sformatf("b2b%0d_ready", k), DW'(out_mem_ready), DW'(1));
            step();
            if (k >= 1 && k <= 3) begin
                chk($sformatf("b2b%0d_wr", k), DW'(out_write_register), DW'(1));
                chk($sformatf("b2b%0d_rd", k), DW'(out_rd), DW'(20 + k - 1));
                chk($sformatf("b2b%0d_data", k), out_write_data, mkd(200 + (k - 1) * 10));
            end else begin
                chk($sformatf("b2b%0d_wr", k), DW'(out_write_register), DW'(0));
            end
        end

        // Streak limiter: continuous ALU request against a non-empty FIFO
        in_alu_valid = 1'b1; in_alu_warp = 1'b0; in_alu_mask = 4'b1111;
        in_alu_wb = 1'b1; in_alu_rd = 5'd9; in_alu_data = mkd(900);
        in_mem_valid = 1'b1;
        k_push = 0;
        for (int c = 0; c < 11; c++) begin
            in_mem_rd = 5'(10 + k_push);
            in_mem_data = mkd(1000 + k_push * 10);
            @(negedge clk);
            chk($sformatf("stk%0d_stall", c), DW'(out_alu_stall), DW'(e4_stall[c]));
            chk($sformatf("stk%0d_ready", c), DW'(out_mem_ready), DW'(e4_ready[c]));
            pushed = in_mem_valid && out_mem_ready;
            step();
            chk($sformatf("stk%0d_rd", c), DW'(out_rd), DW'(e4_rd[c]));
            chk($sformatf("stk%0d_wr", c), DW'(out_write_register), DW'(1));
            if (pushed) k_push++;
        end

        // Reset with two entries queued and the ALU stalled
        in_mem_rd = 5'(10 + k_push);
        @(negedge clk);
        chk("pre_rst_stall", DW'(out_alu_stall), DW'(1));
        chk("pre_rst_ready", DW'(out_mem_ready), DW'(0));
        #2 reset = 1'b1;
        #1;
        chk("arst_wr", DW'(out_write_register), DW'(0));
        chk("arst_valid", DW'(out_valid), DW'(0));
        chk("arst_rd", DW'(out_rd), DW'(0));
        chk("arst_data", out_write_data, DW'(0));
        chk("arst_warp", DW'(out_wb_warp), DW'(0));
        chk("arst_ready", DW'(out_mem_ready), DW'(1));
        in_alu_valid = 1'b0;
        in_mem_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("post_rst%0d_wr", c), DW'(out_write_register), DW'(0));
            chk($sformatf("post_rst%0d_valid", c), DW'(out_valid), DW'(0));
            chk($sformatf("post_rst%0d_ready", c), DW'(out_mem_ready), DW'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
